// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
// Provides register word offsets, CTRL bit positions, FSM state type
// and MODE encodings used by timer_counter.
package tc_pkg;

    // Register word offsets (addr[3:2])
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    // CTRL bit indices
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    // Timer FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } tc_state_e;

    // MODE field encodings (2 and 3 behave as one-shot)
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with interrupt.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low reset
//   addr   - byte address from bridge, only [3:2] decoded
//   we     - write strobe, already qualified by the bridge address hit
//   wd     - write data
//   rd     - read data, combinational from addr[3:2]
//   irq    - interrupt request = IM & irq_flag
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only).
module timer_counter #(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);
    import tc_pkg::*;

    tc_state_e   r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;

    tc_state_e   w_state_nxt;
    logic [3:0]  w_ctrl_nxt;
    logic [31:0] w_preset_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;

    logic [1:0]  w_off;
    logic        w_en;
    logic [1:0]  w_mode;
    logic        w_unused_addr;

    assign w_off         = addr[3:2];
    assign w_en          = r_ctrl[CTRL_EN];
    assign w_mode        = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign w_unused_addr = ^{addr[31:4], addr[1:0]};

    // FSM and register-file next values; the bus write is applied after
    // the FSM update so a same-cycle CPU write overrides FSM changes.
    always_comb begin
        w_state_nxt  = r_state;
        w_ctrl_nxt   = r_ctrl;
        w_preset_nxt = r_preset;
        w_count_nxt  = r_count;
        w_flag_nxt   = r_flag;

        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = S_INT;
                    w_flag_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count - 32'd1;
                end
            end
            S_INT: begin
                w_state_nxt = S_IDLE;
                if (w_mode == MODE_AUTO) begin
                    // auto-reload: EN stays set, flag is a one-cycle pulse
                    w_flag_nxt = 1'b0;
                end else begin
                    w_ctrl_nxt[CTRL_EN] = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (we) begin
            case (w_off)
                TC_CTRL: begin
                    w_ctrl_nxt = wd[3:0];
                    w_flag_nxt = 1'b0;
                end
                TC_PRESET: begin
                    w_preset_nxt = wd;
                    w_flag_nxt   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ctrl   <= '0;
            r_preset <= RESET_PRESET;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_preset <= w_preset_nxt;
            r_count  <= w_count_nxt;
            r_flag   <= w_flag_nxt;
        end
    end

    always_comb begin
        rd = '0;
        case (w_off)
            TC_CTRL:   rd = {28'b0, r_ctrl};
            TC_PRESET: rd = r_preset;
            TC_COUNT:  rd = r_count;
            default:   rd = '0;
        endcase
    end

    assign irq = r_ctrl[CTRL_IM] & r_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with literal
// expectations plus randomized bus traffic, all compared every cycle
// against a behavioural model of the timer.
module tb_timer_counter;

    localparam logic [31:0] RP = 32'h0000_1234;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    timer_counter #(.RESET_PRESET(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases of one timer run: waiting for EN, loading, counting, expiry.
    localparam int PH_WAIT = 0, PH_LOADING = 1, PH_RUNNING = 2, PH_EXPIRED = 3;

    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;
    int          m_phase;

    function automatic void model_edge(input logic r, input logic w,
                                       input logic [31:0] a, input logic [31:0] d);
        if (!r) begin
            m_ctrl = 4'h0; m_preset = RP; m_count = 0; m_flag = 0; m_phase = PH_WAIT;
            return;
        end
        case (m_phase)
            PH_WAIT:    if (m_ctrl[0]) m_phase = PH_LOADING;
            PH_LOADING: begin m_count = m_preset; m_phase = PH_RUNNING; end
            PH_RUNNING: begin
                if (!m_ctrl[0]) m_phase = PH_WAIT;
                else if (m_count == 0) begin m_phase = PH_EXPIRED; m_flag = 1; end
                else m_count = m_count - 1;
            end
            default: begin
                m_phase = PH_WAIT;
                if (m_ctrl[2:1] == 2'd1) m_flag = 0;
                else m_ctrl[0] = 1'b0;
            end
        endcase
        if (w) begin
            if (a[3:2] == 2'd0) begin m_ctrl = d[3:0]; m_flag = 0; end
            else if (a[3:2] == 2'd1) begin m_preset = d; m_flag = 0; end
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {28'b0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_irq();
        return m_ctrl[3] & m_flag;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_rd", rd, exp_rd(addr));
            check("cmp_irq", {31'b0, irq}, {31'b0, exp_irq()});
        end
    end

    // one clock edge with the given inputs; model follows the same edge
    task automatic tick(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        reset = r; we = w; addr = a; wd = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        we = 1'b0; reset = 1'b1;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rd, exp);
    endtask

    int pulses[$];
    int r;

    initial begin
        reset = 1'b0; we = 1'b0; addr = '0; wd = '0;
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk_en = 1'b1;

        // 1: random writes, then reset held two cycles
        for (int i = 0; i < 5; i++)
            tick(1'b1, 1'b1, {$urandom_range(0, 1), 2'b00}, $urandom);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        peek("rst_ctrl", 32'h7F00, 32'h0);
        peek("rst_count", 32'h7F08, 32'h0);
        peek("rst_preset", 32'h7F04, RP);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // 2: one-shot, N=3
        tick(1'b1, 1'b1, 32'h7F04, 32'd3);
        tick(1'b1, 1'b1, 32'h7F00, 32'h9);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("os_load", rd, 32'd0);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("os_c3", rd, 32'd3);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("os_c2", rd, 32'd2);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("os_c1", rd, 32'd1);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("os_c0", rd, 32'd0);
        check("os_irq_lo", {31'b0, irq}, 32'd0);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("os_irq_hi", {31'b0, irq}, 32'd1);
        tick(1'b1, 1'b0, 32'h7F00, 0); check("os_ctrl", rd, 32'h8);
        check("os_irq_held", {31'b0, irq}, 32'd1);
        tick(1'b1, 1'b0, 32'h7F00, 0); check("os_irq_held2", {31'b0, irq}, 32'd1);
        tick(1'b1, 1'b1, 32'h7F00, 32'h0); check("os_irq_clr", {31'b0, irq}, 32'd0);

        // 3: auto-reload, N=2 -> pulse every 6 cycles
        tick(1'b1, 1'b1, 32'h7F04, 32'd2);
        tick(1'b1, 1'b1, 32'h7F00, 32'hB);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b1, 1'b0, 32'h7F08, 0);
            if (irq === 1'b1) pulses.push_back(i);
        end
        check("ar_npulses", pulses.size(), 32'd6);
        if (pulses.size() > 0) check("ar_first", pulses[0], 32'd5);
        for (int i = 1; i < pulses.size(); i++)
            check("ar_period", pulses[i] - pulses[i-1], 32'd6);
        tick(1'b1, 1'b1, 32'h7F00, 32'h0);
        tick(1'b1, 1'b0, 32'h7F00, 0);

        // 4: one-shot with IM=0
        tick(1'b1, 1'b1, 32'h7F04, 32'd1);
        tick(1'b1, 1'b1, 32'h7F00, 32'h1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 32'h7F00, 0);
        check("im0_ctrl", rd, 32'h0);
        check("im0_irq", {31'b0, irq}, 32'd0);
        tick(1'b1, 1'b1, 32'h7F00, 32'h8);
        check("im0_irq_after", {31'b0, irq}, 32'd0);
        check("im0_ctrl_after", rd, 32'h8);

        // 5: PRESET write during count, then EN cleared
        tick(1'b1, 1'b1, 32'h7F04, 32'd8);
        tick(1'b1, 1'b1, 32'h7F00, 32'h1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h7F08, 0);
        check("pw_c5", rd, 32'd5);
        tick(1'b1, 1'b1, 32'h7F04, 32'd100);
        peek("pw_c4", 32'h7F08, 32'd4);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("pw_c3", rd, 32'd3);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("pw_c2", rd, 32'd2);
        tick(1'b1, 1'b1, 32'h7F00, 32'h0);
        peek("dis_c1", 32'h7F08, 32'd1);
        tick(1'b1, 1'b0, 32'h7F08, 0);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("dis_frozen", rd, 32'd1);
        check("dis_irq", {31'b0, irq}, 32'd0);

        // 6: write to COUNT ignored; reset mid-count
        tick(1'b1, 1'b1, 32'h7F08, 32'hFFFF);
        peek("ro_count", 32'h7F08, 32'd1);
        tick(1'b1, 1'b1, 32'h7F04, 32'd10);
        tick(1'b1, 1'b1, 32'h7F00, 32'h1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h7F08, 0);
        check("mid_c8", rd, 32'd8);
        tick(1'b0, 1'b0, 32'h7F08, 0); check("mid_rst", rd, 32'd0);
        tick(1'b1, 1'b0, 32'h7F08, 0); check("mid_idle", rd, 32'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                tick(1'b0, 1'b0, $urandom, 0);
            end else if (r < 22) begin
                logic [31:0] a;
                logic [31:0] d;
                a = {$urandom} & 32'hFFFF_FFFC;
                d = $urandom;
                if ($urandom_range(0, 1) == 0) d = (d & 32'hE) | 32'h1;
                else if (a[3:2] == 2'd1) d = $urandom_range(0, 6);
                tick(1'b1, 1'b1, a, d);
            end else begin
                tick(1'b1, 1'b0, $urandom, 0);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
